// File: rtl/sdram_responder_if.sv
// SDRAM command/data bus between a memory controller (master) and the device emulator (slave).
interface sdram_responder_if;
    logic        sd_CKE;
    logic        sd_CS;
    logic        sd_RAS;
    logic        sd_CAS;
    logic        sd_WE;
    logic [1:0]  sd_BA;
    logic [12:0] sd_A;
    logic [15:0] sd_DQ_in;
    logic        sd_LDM;
    logic        sd_UDM;
    logic [15:0] sd_DQ_out;
    logic        sd_DQ_oe;

    modport master (
        output sd_CKE, sd_CS, sd_RAS, sd_CAS, sd_WE, sd_BA, sd_A, sd_DQ_in, sd_LDM, sd_UDM,
        input  sd_DQ_out, sd_DQ_oe
    );

    modport slave (
        input  sd_CKE, sd_CS, sd_RAS, sd_CAS, sd_WE, sd_BA, sd_A, sd_DQ_in, sd_LDM, sd_UDM,
        output sd_DQ_out, sd_DQ_oe
    );
endinterface

// File: rtl/sdram_responder.sv
// SDRAM device emulator: decodes controller commands, tracks init/mode/open rows, checks
// command spacing and serves write/read bursts from a 256x16 internal RAM.
module sdram_responder #(
    parameter int tRP  = 3,
    parameter int tMRD = 2,
    parameter int tRFC = 11,
    parameter int tRCD = 3
) (
    input  logic             clk25,
    input  logic             rst,
    sdram_responder_if.slave sd,
    output logic             initDone,
    output logic [12:0]      modeReg,
    output logic             errTiming,
    output logic             errState
);
    typedef enum logic [2:0] {
        WAIT_PRE0, WAIT_EMR, WAIT_MR0, WAIT_PRE1, WAIT_AR0, WAIT_AR1, WAIT_MR1, READY
    } initState_t;

    // Counters hold spacing-1, so a command exactly N cycles later sees zero.
    localparam logic [7:0] LD_RP  = 8'(tRP - 1);
    localparam logic [7:0] LD_MRD = 8'(tMRD - 1);
    localparam logic [7:0] LD_RFC = 8'(tRFC - 1);
    localparam logic [7:0] LD_RCD = 8'(tRCD - 1);

    initState_t  r_state;
    logic        r_initDone;
    logic [12:0] r_modeReg;
    logic        r_errTiming;
    logic        r_errState;
    logic [7:0]  r_guard;
    logic [3:0]  r_open;
    logic [1:0]  r_row [4];
    logic [7:0]  r_rcd [4];
    logic [15:0] r_mem [256];

    logic        r_rdPend;
    logic [1:0]  r_rdDelay;
    logic [3:0]  r_rdPendHi, r_rdPendCol, r_rdPendBl;
    logic [3:0]  r_rdHi, r_rdCol, r_rdBl, r_rdBeats;
    logic [15:0] r_dqOut;
    logic        r_dqOe;
    logic [3:0]  r_wrHi, r_wrCol, r_wrBl, r_wrBeats;

    logic        w_live, w_isLoad, w_isAr, w_isPre, w_isAct, w_isWr, w_isRd, w_nonNop;
    logic [2:0]  w_cmd;
    logic        w_ready, w_expected, w_bankOpen, w_bankBusy, w_rwStart, w_readBusy, w_stateErr;
    initState_t  w_initNext;
    logic [3:0]  w_bl, w_hi;
    logic [1:0]  w_cl;
    logic        w_blOk, w_clOk;

    function automatic logic [3:0] nextCol(input logic [3:0] col, input logic [3:0] bl);
        logic [3:0] mask;
        mask = bl - 4'd1;
        return (col & ~mask) | ((col + 4'd1) & mask);
    endfunction

    assign w_live     = sd.sd_CKE && !sd.sd_CS;
    assign w_cmd      = {sd.sd_RAS, sd.sd_CAS, sd.sd_WE};
    assign w_isLoad   = w_live && (w_cmd == 3'b000);
    assign w_isAr     = w_live && (w_cmd == 3'b001);
    assign w_isPre    = w_live && (w_cmd == 3'b010);
    assign w_isAct    = w_live && (w_cmd == 3'b011);
    assign w_isWr     = w_live && (w_cmd == 3'b100);
    assign w_isRd     = w_live && (w_cmd == 3'b101);
    assign w_nonNop   = w_isLoad || w_isAr || w_isPre || w_isAct || w_isWr || w_isRd;
    assign w_ready    = (r_state == READY);
    assign w_bankOpen = r_open[sd.sd_BA];
    assign w_bankBusy = (r_rcd[sd.sd_BA] != 8'd0);
    assign w_rwStart  = w_ready && (w_isRd || w_isWr) && w_bankOpen;
    assign w_readBusy = r_rdPend || r_dqOe || (r_rdBeats != 4'd0);
    assign w_hi       = {sd.sd_BA, r_row[sd.sd_BA]};

    always_comb begin
        w_expected = 1'b0;
        w_initNext = r_state;
        case (r_state)
            WAIT_PRE0: begin w_expected = w_isPre && sd.sd_A[10];            w_initNext = WAIT_EMR;  end
            WAIT_EMR:  begin w_expected = w_isLoad && (sd.sd_BA == 2'b01);   w_initNext = WAIT_MR0;  end
            WAIT_MR0:  begin w_expected = w_isLoad && (sd.sd_BA == 2'b00);   w_initNext = WAIT_PRE1; end
            WAIT_PRE1: begin w_expected = w_isPre && sd.sd_A[10];            w_initNext = WAIT_AR0;  end
            WAIT_AR0:  begin w_expected = w_isAr;                            w_initNext = WAIT_AR1;  end
            WAIT_AR1:  begin w_expected = w_isAr;                            w_initNext = WAIT_MR1;  end
            WAIT_MR1:  begin w_expected = w_isLoad && (sd.sd_BA == 2'b00);   w_initNext = READY;     end
            default:   begin w_expected = 1'b0;                              w_initNext = READY;     end
        endcase
        if (!w_expected) w_initNext = r_state;
    end

    // Illegal burst-length or latency codes fall back to 2 independently.
    always_comb begin
        w_blOk = 1'b1;
        w_bl   = 4'd2;
        case (r_modeReg[2:0])
            3'b001:  w_bl = 4'd2;
            3'b010:  w_bl = 4'd4;
            3'b011:  w_bl = 4'd8;
            default: w_blOk = 1'b0;
        endcase
        w_clOk = 1'b1;
        w_cl   = 2'd2;
        case (r_modeReg[6:4])
            3'b010:  w_cl = 2'd2;
            3'b011:  w_cl = 2'd3;
            default: w_clOk = 1'b0;
        endcase
    end

    always_comb begin
        w_stateErr = 1'b0;
        if (!w_ready) begin
            w_stateErr = w_nonNop && !w_expected;
        end else begin
            if (w_isAct && w_bankOpen)                   w_stateErr = 1'b1;
            if ((w_isRd || w_isWr) && !w_bankOpen)       w_stateErr = 1'b1;
            if (w_rwStart && !w_blOk)                    w_stateErr = 1'b1;
            if (w_rwStart && w_isRd && !w_clOk)          w_stateErr = 1'b1;
            if (w_rwStart && w_isWr && w_readBusy)       w_stateErr = 1'b1;
            if (w_isAr && (r_open != 4'd0))              w_stateErr = 1'b1;
        end
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_state     <= WAIT_PRE0;
            r_initDone  <= 1'b0;
            r_modeReg   <= 13'd0;
            r_errTiming <= 1'b0;
            r_errState  <= 1'b0;
            r_guard     <= 8'd0;
            r_open      <= 4'd0;
            for (int b = 0; b < 4; b++) begin
                r_row[b] <= 2'd0;
                r_rcd[b] <= 8'd0;
            end
        end else if (sd.sd_CKE) begin
            if (r_guard != 8'd0) r_guard <= r_guard - 8'd1;
            for (int b = 0; b < 4; b++) begin
                if (r_rcd[b] != 8'd0) r_rcd[b] <= r_rcd[b] - 8'd1;
            end
            if (w_isPre)       r_guard <= LD_RP;
            else if (w_isLoad) r_guard <= LD_MRD;
            else if (w_isAr)   r_guard <= LD_RFC;
            if (!w_ready) begin
                r_state    <= w_initNext;
                r_initDone <= (w_initNext == READY);
            end
            if (w_nonNop && (r_guard != 8'd0))                 r_errTiming <= 1'b1;
            if (w_ready && (w_isRd || w_isWr) && w_bankBusy)   r_errTiming <= 1'b1;
            if (w_stateErr)                                    r_errState  <= 1'b1;
            if (w_isLoad && (sd.sd_BA == 2'b00) && (w_ready || w_expected)) r_modeReg <= sd.sd_A;
            if (w_isPre && (w_ready || w_expected)) begin
                if (sd.sd_A[10]) r_open <= 4'd0;
                else             r_open[sd.sd_BA] <= 1'b0;
            end
            if (w_ready && w_isAct && !w_bankOpen) begin
                r_open[sd.sd_BA] <= 1'b1;
                r_row[sd.sd_BA]  <= sd.sd_A[1:0];
                r_rcd[sd.sd_BA]  <= LD_RCD;
            end
        end
    end

    // A new READ/WRITE ends the write after the beat sampled on its own command edge.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_wrHi    <= 4'd0;
            r_wrCol   <= 4'd0;
            r_wrBl    <= 4'd2;
            r_wrBeats <= 4'd0;
        end else if (sd.sd_CKE) begin
            if (r_wrBeats != 4'd0) begin
                r_wrCol   <= nextCol(r_wrCol, r_wrBl);
                r_wrBeats <= r_wrBeats - 4'd1;
            end
            if (w_rwStart) begin
                if (w_isWr) begin
                    r_wrHi    <= w_hi;
                    r_wrCol   <= sd.sd_A[3:0];
                    r_wrBl    <= w_bl;
                    r_wrBeats <= w_bl;
                end else begin
                    r_wrBeats <= 4'd0;
                end
            end
        end
    end

    always_ff @(posedge clk25) begin
        if (sd.sd_CKE && (r_wrBeats != 4'd0)) begin
            if (!sd.sd_LDM) r_mem[{r_wrHi, r_wrCol}][7:0]  <= sd.sd_DQ_in[7:0];
            if (!sd.sd_UDM) r_mem[{r_wrHi, r_wrCol}][15:8] <= sd.sd_DQ_in[15:8];
        end
    end

    // An older read keeps the bus until a newer read's first beat replaces it.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_rdPend    <= 1'b0;
            r_rdDelay   <= 2'd0;
            r_rdPendHi  <= 4'd0;
            r_rdPendCol <= 4'd0;
            r_rdPendBl  <= 4'd2;
            r_rdHi      <= 4'd0;
            r_rdCol     <= 4'd0;
            r_rdBl      <= 4'd2;
            r_rdBeats   <= 4'd0;
            r_dqOut     <= 16'd0;
            r_dqOe      <= 1'b0;
        end else if (sd.sd_CKE) begin
            if (w_rwStart && w_isWr) begin
                r_rdPend  <= 1'b0;
                r_rdBeats <= 4'd0;
                r_dqOut   <= 16'd0;
                r_dqOe    <= 1'b0;
            end else begin
                if (r_rdPend && (r_rdDelay == 2'd1)) begin
                    r_dqOut   <= r_mem[{r_rdPendHi, r_rdPendCol}];
                    r_dqOe    <= 1'b1;
                    r_rdHi    <= r_rdPendHi;
                    r_rdCol   <= nextCol(r_rdPendCol, r_rdPendBl);
                    r_rdBl    <= r_rdPendBl;
                    r_rdBeats <= r_rdPendBl - 4'd1;
                    r_rdPend  <= 1'b0;
                end else begin
                    if (r_rdPend) r_rdDelay <= r_rdDelay - 2'd1;
                    if (r_rdBeats != 4'd0) begin
                        r_dqOut   <= r_mem[{r_rdHi, r_rdCol}];
                        r_dqOe    <= 1'b1;
                        r_rdCol   <= nextCol(r_rdCol, r_rdBl);
                        r_rdBeats <= r_rdBeats - 4'd1;
                    end else begin
                        r_dqOut <= 16'd0;
                        r_dqOe  <= 1'b0;
                    end
                end
                if (w_rwStart && w_isRd) begin
                    r_rdPend    <= 1'b1;
                    r_rdDelay   <= w_cl - 2'd1;
                    r_rdPendHi  <= w_hi;
                    r_rdPendCol <= sd.sd_A[3:0];
                    r_rdPendBl  <= w_bl;
                end
            end
        end
    end

    assign sd.sd_DQ_out = r_dqOut;
    assign sd.sd_DQ_oe  = r_dqOe;
    assign initDone     = r_initDone;
    assign modeReg      = r_modeReg;
    assign errTiming    = r_errTiming;
    assign errState     = r_errState;
endmodule

// File: doc/sdram_responder.md
# sdram_responder

Synthesizable single-data-rate SDRAM device emulator that sits on the far end of the SDRAM command/data bus, in place of the physical memory, for loopback bring-up and regression of the memory controller. It decodes CS/RAS/CAS/WE commands each clk25 cycle and tracks the power-up sequence, mode register and per-bank open rows. It checks command spacing against the datasheet timings, stores write bursts in a small internal RAM and returns read bursts after the programmed CAS latency. Protocol and timing violations are reported on sticky error flags.

## Interface
- Parameters:
- tRP, 3, min cycles from PRECHARGE to next non-NOP command
- tMRD, 2, min cycles from LOAD MODE to next non-NOP command
- tRFC, 11, min cycles from AUTO REFRESH to next non-NOP command
- tRCD, 3, min cycles from ACTIVE to READ/WRITE on that bank
- Ports (reset rst, asynchronous, active-high; clock clk25):
- clk25  in  1  device clock; all bus inputs sampled on rising edge
- rst  in  1  asynchronous active-high reset
- sd_CKE  in  1  clock enable; low = command ignored, bursts frozen
- sd_CS  in  1  chip select, active low; high = NOP
- sd_RAS, sd_CAS, sd_WE  in  1 each  command bits {RAS,CAS,WE}
- sd_BA  in  2  bank address
- sd_A  in  13  address; A10 = all-banks flag on PRECHARGE
- sd_DQ_in  in  16  write data from controller
- sd_LDM, sd_UDM  in  1 each  write byte masks, active high
- sd_DQ_out  out  16  read data
- sd_DQ_oe  out  1  high while sd_DQ_out is valid
- initDone  out  1  power-up sequence completed correctly
- modeReg  out  13  last value loaded with BA=00
- errTiming  out  1  sticky: spacing violation
- errState  out  1  sticky: illegal command for current state

## Operation
- Commands {RAS,CAS,WE}: 000 LOAD MODE, 001 AUTO REFRESH, 010 PRECHARGE, 011 ACTIVE, 100 WRITE, 101 READ, 111 NOP; 110 is treated as NOP. CS high or CKE low = NOP.
- Init FSM: WAIT_PRE0 -> (PRECHARGE A10=1) WAIT_EMR -> (LOAD BA=01) WAIT_MR0 -> (LOAD BA=00) WAIT_PRE1 -> (PRECHARGE A10=1) WAIT_AR0 -> AR -> WAIT_AR1 -> AR -> WAIT_MR1 -> (LOAD BA=00) READY.
- READY asserts initDone. Any non-NOP command other than the one expected while not READY sets errState; the FSM holds its state.
- Mode register: BL from modeReg[2:0] (001=2, 010=4, 011=8). CL from modeReg[6:4] (010=2, 011=3). An illegal BL or CL code sets errState on the READ/WRITE that uses it, and the command then uses BL=2, CL=2.
- Banks: 4 open flags plus row registers. ACTIVE to an open bank: errState. READ/WRITE to a closed bank: errState, burst not started. PRECHARGE with A10=1 closes all banks; with A10=0 it closes bank BA.
- Memory: 256 x 16, index {BA, row[1:0], col[3:0]}, col = A[3:0]. Contents are not reset.
- Burst addressing is sequential, wrapping within the BL-aligned block. Example: BL=4, col 6 gives 6,7,4,5.
- WRITE: data is taken from sd_DQ_in on the BL cycles starting 1 cycle after the command. LDM masks [7:0] and UDM masks [15:8].
- READ: sd_DQ_out/sd_DQ_oe are valid for BL cycles starting CL cycles after the command.
- A new READ/WRITE truncates any burst in progress; the new burst owns the bus from its own start cycle.
- A WRITE issued while read data is pending or driving sets errState and truncates the read.
- AUTO REFRESH or ACTIVE issued while a bank is open in READY sets errState (AR) or is checked as above (ACTIVE).

## Timing
- Reset: sd_DQ_out=0, sd_DQ_oe=0, initDone=0, modeReg=0, errTiming=0, errState=0. Init FSM goes to WAIT_PRE0, all banks closed, all counters 0.
- A global guard counter is loaded on PRECHARGE (tRP), LOAD (tMRD) and AR (tRFC). Any non-NOP command while the counter is non-zero sets errTiming. The command is still executed.
- A per-bank counter is loaded with tRCD on ACTIVE. A READ/WRITE to that bank while its counter is non-zero sets errTiming.
- Counters decrement only when sd_CKE is high. Rule: a command exactly N cycles after one with spacing N is legal.
- Error flags are set in the cycle after the offending command and clear only on rst.
- rst mid-burst: sd_DQ_oe drops immediately (asynchronous) and any pending write beats are discarded.

## Test plan
- Full legal init sequence with NOP gaps of exactly tRP/tMRD/tRFC -> initDone=1 after final LOAD, modeReg=13'h0021, no errors.
- After init: ACTIVE bank0 row0, WRITE col0 at tRCD with data 5555, AAAA, then READ col0 -> sd_DQ_oe high for exactly 2 cycles starting 2 cycles after READ, data 5555 then AAAA.
- AUTO REFRESH issued 10 cycles after a previous AUTO REFRESH (tRFC=11) -> errTiming=1 on the next cycle, errState=0.
- READ to bank 2 while bank 2 is closed -> errState=1, sd_DQ_oe stays 0.
- BL=4, CL=3: WRITE col 6 with 1,2,3,4 and UDM=1 on the second beat, then READ col 4 -> 3,4,1,0x0002 with the upper byte of 0x0002 holding its prior content, first beat 3 cycles after READ.
- rst asserted during a read burst -> sd_DQ_oe=0 immediately, initDone=0, error flags 0.
